// File: rtl/rpm_calculator.sv
// rpm_calculator
//   Converts measured pulse periods (in clk cycles) into shaft RPM.
//   Each new period goes into a small ring buffer whose entries are averaged
//   (boxcar, 2**AVG_LOG2 deep). The averaged period is scaled by
//   PULSES_PER_REV and divided into CLK_HZ*60 with a bit-serial restoring
//   divider. A watchdog declares the shaft stalled when no period arrives
//   within TIMEOUT_CYCLES.
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   period        in   32     measured period in clk cycles
//   period_valid  in   1      one-cycle strobe qualifying period
//   rpm           out  RPM_W  latest RPM result (registered)
//   rpm_valid     out  1      one-cycle strobe: rpm updated
//   busy          out  1      conversion in progress (LOAD/DIV/DONE)
//   stalled       out  1      timeout condition holds
module rpm_calculator #(
    parameter int unsigned CLK_HZ         = 1_000_000,
    parameter int unsigned PULSES_PER_REV = 2,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned RPM_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      period,
    input  logic             period_valid,
    output logic [RPM_W-1:0] rpm,
    output logic             rpm_valid,
    output logic             busy,
    output logic             stalled
);

    localparam int unsigned      DEPTH        = 1 << AVG_LOG2;
    localparam int unsigned      PTR_W        = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned      SUM_W        = 32 + AVG_LOG2;
    localparam logic [31:0]      NUM_CONST    = 32'(CLK_HZ * 60);
    localparam logic [32:0]      RPM_MAX      = (33'd1 << RPM_W) - 33'd1;
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_SAT  = 32'(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       samp_reg [DEPTH];
    logic              primed_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic              pend_valid_reg;
    logic [31:0]       pend_data_reg;
    logic [31:0]       timeout_cnt_reg;
    logic              stalled_reg;
    logic              rpm_valid_reg;
    logic [RPM_W-1:0]  rpm_reg;
    logic [31:0]       den_reg;
    logic [31:0]       quo_reg;     // dividend shifts out of the top, quotient shifts in
    logic [31:0]       rem_reg;
    logic [4:0]        bit_cnt_reg;

    logic              timeout_hit;
    logic              accept_go;
    logic [31:0]       accept_data;
    logic [SUM_W-1:0]  sum_c;
    logic [31:0]       avg_c;
    logic [39:0]       den_full;
    logic [31:0]       den_sat;
    logic [32:0]       rem_shift;
    logic              rem_ge;
    logic [31:0]       rem_diff;
    logic [RPM_W-1:0]  quo_sat;

    // A strobe in the same cycle always beats the watchdog.
    assign timeout_hit = !period_valid && (timeout_cnt_reg == TIMEOUT_LAST);
    // A fresh strobe is newer than anything parked in the pending register.
    assign accept_go   = (state_reg == ST_IDLE) && (period_valid || pend_valid_reg) && !timeout_hit;
    assign accept_data = period_valid ? period : pend_data_reg;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sum_c = sum_c + SUM_W'(samp_reg[i]);
        end
    end

    assign avg_c    = sum_c[SUM_W-1:AVG_LOG2];
    assign den_full = {8'd0, avg_c} * 40'(PULSES_PER_REV);
    assign den_sat  = (den_full[39:32] != 8'd0) ? 32'hFFFF_FFFF : den_full[31:0];

    // Restoring step: the true difference is below den (< 2**32), so the
    // low 32 bits of the subtraction are exact.
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign rem_ge    = (rem_shift >= {1'b0, den_reg});
    assign rem_diff  = rem_shift[31:0] - den_reg;

    assign quo_sat = ({1'b0, quo_reg} > RPM_MAX) ? RPM_MAX[RPM_W-1:0] : quo_reg[RPM_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept_go) state_next = ST_LOAD;
                ST_LOAD: state_next = ST_DIV;
                ST_DIV:  if (bit_cnt_reg == 5'd31) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                samp_reg[i] <= '0;
            end
            primed_reg      <= 1'b0;
            wr_ptr_reg      <= '0;
            pend_valid_reg  <= 1'b0;
            pend_data_reg   <= '0;
            timeout_cnt_reg <= '0;
            stalled_reg     <= 1'b1;
            rpm_valid_reg   <= 1'b0;
            rpm_reg         <= '0;
            den_reg         <= '0;
            quo_reg         <= '0;
            rem_reg         <= '0;
            bit_cnt_reg     <= '0;
        end else begin
            rpm_valid_reg <= 1'b0;

            if (period_valid) begin
                timeout_cnt_reg <= '0;
            end else if (timeout_cnt_reg != TIMEOUT_SAT) begin
                timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
            end

            if (timeout_hit) begin
                pend_valid_reg <= 1'b0;
            end else if ((state_reg != ST_IDLE) && period_valid) begin
                pend_valid_reg <= 1'b1;
                pend_data_reg  <= period;
            end else if (accept_go) begin
                pend_valid_reg <= 1'b0;
            end

            // Unprimed buffer: the first sample fills every slot so the
            // average starts at that sample instead of ramping from zero.
            if (accept_go) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (!primed_reg || (wr_ptr_reg == PTR_W'(i))) begin
                        samp_reg[i] <= accept_data;
                    end
                end
                primed_reg <= 1'b1;
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            end

            if (timeout_hit) begin
                primed_reg    <= 1'b0;
                stalled_reg   <= 1'b1;
                rpm_reg       <= '0;
                rpm_valid_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ST_LOAD: begin
                        den_reg     <= den_sat;
                        quo_reg     <= NUM_CONST;
                        rem_reg     <= '0;
                        bit_cnt_reg <= '0;
                    end
                    ST_DIV: begin
                        quo_reg     <= {quo_reg[30:0], rem_ge};
                        rem_reg     <= rem_ge ? rem_diff : rem_shift[31:0];
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                    ST_DONE: begin
                        rpm_reg       <= (den_reg == 32'd0) ? RPM_MAX[RPM_W-1:0] : quo_sat;
                        rpm_valid_reg <= 1'b1;
                        stalled_reg   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rpm       = rpm_reg;
    assign rpm_valid = rpm_valid_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign stalled   = stalled_reg;

endmodule

// File: tb/tb_rpm_calculator.sv
// tb_rpm_calculator
//   Table of periods with hand-derived RPM results, directed multi-cycle
//   sequences (pending overwrite, stall, mid-conversion reset) and a random
//   phase, all shadowed by a cycle-by-cycle reference model of the outputs.
module tb_rpm_calculator;

    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned PPR      = 2;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned RPM_W    = 16;
    localparam int unsigned TO       = 300;
    localparam int unsigned DEPTH    = 1 << AVG_LOG2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] period = '0;
    logic        period_valid = 1'b0;
    logic [15:0] rpm;
    logic        rpm_valid, busy, stalled;

    int checks = 0;
    int errors = 0;

    rpm_calculator #(
        .CLK_HZ(CLK_HZ), .PULSES_PER_REV(PPR), .AVG_LOG2(AVG_LOG2),
        .RPM_W(RPM_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .period(period), .period_valid(period_valid),
        .rpm(rpm), .rpm_valid(rpm_valid), .busy(busy), .stalled(stalled)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Outputs after each edge: a conversion started at edge A reports at edge
    // A+34 with floor(CLK_HZ*60 / den), den from the mean of the last DEPTH samples.
    bit               m_busy, m_pend, m_valid, m_stalled;
    int unsigned      m_cyc, m_done_at, m_tcnt;
    logic [31:0]      m_pend_val;
    logic [15:0]      m_rpm, m_result;
    longint unsigned  hist[$];

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_valid = 0; m_stalled = 1;
        m_cyc = 0; m_done_at = 0; m_tcnt = 0; m_rpm = 0; m_result = 0;
        hist.delete();
    endtask

    task automatic model_accept(input logic [31:0] s);
        longint unsigned sum, den, q;
        if (hist.size() == 0) begin
            for (int i = 0; i < int'(DEPTH); i++) hist.push_back(s);
        end else begin
            hist.push_back(s);
            void'(hist.pop_front());
        end
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        den = (sum / DEPTH) * PPR;
        if (den > 64'hFFFF_FFFF) den = 64'hFFFF_FFFF;
        if (den == 0) m_result = 16'hFFFF;
        else begin
            q = (longint'(CLK_HZ) * 60) / den;
            m_result = (q > 65535) ? 16'hFFFF : 16'(q);
        end
        m_busy = 1;
        m_done_at = m_cyc + 34;
    endtask

    task automatic model_step(input bit pv, input logic [31:0] p);
        bit stall_evt;
        m_cyc++;
        m_valid = 0;
        stall_evt = 0;
        if (pv) m_tcnt = 0;
        else if (m_tcnt < TO) begin
            m_tcnt++;
            stall_evt = (m_tcnt == TO);
        end
        if (stall_evt) begin
            m_stalled = 1; m_rpm = 0; m_valid = 1;
            m_busy = 0; m_pend = 0;
            hist.delete();
        end else if (m_busy) begin
            if (pv) begin m_pend = 1; m_pend_val = p; end
            if (m_cyc == m_done_at) begin
                m_rpm = m_result; m_valid = 1; m_stalled = 0; m_busy = 0;
            end
        end else if (pv) begin
            m_pend = 0;
            model_accept(p);
        end else if (m_pend) begin
            m_pend = 0;
            model_accept(m_pend_val);
        end
    endtask

    // Inputs change only just after a rising edge, so the values seen at a
    // falling edge are the ones the following rising edge samples.
    initial begin : monitor
        bit          prev_rst, prev_pv;
        logic [31:0] prev_period;
        logic [18:0] got_v, exp_v;
        prev_rst = 0; prev_pv = 0; prev_period = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            else if (prev_rst) model_step(prev_pv, prev_period);
            got_v = {rpm_valid, busy, stalled, rpm};
            exp_v = {m_valid, m_busy, m_stalled, m_rpm};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL monitor t=%0t got valid/busy/stalled/rpm %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         $time, rpm_valid, busy, stalled, rpm, m_valid, m_busy, m_stalled, m_rpm);
            end
            prev_rst = rst_n; prev_pv = period_valid; prev_period = period;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [31:0] p);
        @(posedge clk); #1;
        period = p; period_valid = 1'b1;
        @(posedge clk); #1;
        period_valid = 1'b0;
    endtask

    task automatic wait_result(input int bound, output bit got, output int lat,
                               output logic [15:0] r, output logic st);
        got = 0; lat = -1; r = 0; st = 0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (rpm_valid) begin
                got = 1; lat = k; r = rpm; st = stalled;
                break;
            end
        end
    endtask

    task automatic do_flush();
        bit seen;
        seen = 0;
        for (int k = 0; k < int'(TO) + 100; k++) begin
            @(negedge clk);
            if (stalled && !busy) begin seen = 1; break; end
        end
        check("flush_stalled", seen, 1);
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] exp_rpm;
        bit          flush;
    } vec_t;

    vec_t tbl[14];

    initial begin : stim
        bit          got, st_b;
        int          lat, n, t1, t2;
        logic [15:0] r, r1, r2;
        logic        st, st2;
        int unsigned gap, sel;
        logic [31:0] p;

        tbl[0]  = '{32'd30000,       16'd1000,  1'b0};
        tbl[1]  = '{32'd10000,       16'd1200,  1'b0};
        tbl[2]  = '{32'd10000,       16'd1500,  1'b0};
        tbl[3]  = '{32'd10000,       16'd2000,  1'b0};
        tbl[4]  = '{32'd10000,       16'd3000,  1'b0};
        tbl[5]  = '{32'd20000,       16'd2400,  1'b0};
        tbl[6]  = '{32'd0,           16'd65535, 1'b1};
        tbl[7]  = '{32'd1,           16'd65535, 1'b1};
        tbl[8]  = '{32'd7,           16'd65535, 1'b1};
        tbl[9]  = '{32'd60000,       16'd500,   1'b1};
        tbl[10] = '{32'd1000,        16'd30000, 1'b1};
        tbl[11] = '{32'd900,         16'd30769, 1'b0};
        tbl[12] = '{32'hFFFF_FFFF,   16'd0,     1'b1};
        tbl[13] = '{32'd15_000_000,  16'd2,     1'b1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rpm", rpm, 0);
        check("reset_rpm_valid", rpm_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_stalled", stalled, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // table-driven conversions
        foreach (tbl[i]) begin
            if (tbl[i].flush) do_flush();
            pulse(tbl[i].period);
            wait_result(60, got, lat, r, st);
            check($sformatf("tbl%0d_valid", i), got, 1);
            check($sformatf("tbl%0d_latency", i), lat, 35);
            check($sformatf("tbl%0d_rpm", i), r, tbl[i].exp_rpm);
            check($sformatf("tbl%0d_stalled", i), st, 0);
        end

        // pending overwrite: strobes at A, A+5, A+10 give two results
        do_flush();
        pulse(32'd30000);
        n = 0; t1 = -1; t2 = -1; r1 = 0; r2 = 0;
        for (int k = 1; k <= 110; k++) begin
            if (k == 5)       begin period = 32'd10000; period_valid = 1'b1; end
            else if (k == 10) begin period = 32'd60000; period_valid = 1'b1; end
            else period_valid = 1'b0;
            @(negedge clk);
            if (rpm_valid) begin
                n++;
                if (n == 1) begin t1 = k - 1; r1 = rpm; end
                else if (n == 2) begin t2 = k - 1; r2 = rpm; end
            end
            @(posedge clk); #1;
        end
        period_valid = 1'b0;
        check("pend_count", n, 2);
        check("pend_t1", t1, 34);
        check("pend_r1", r1, 1000);
        check("pend_t2", t2, 69);
        check("pend_r2", r2, 800);

        // stall after a result, then re-prime with a fresh sample
        pulse(32'd40000);
        n = 0; t1 = -1; t2 = -1; r1 = 0; r2 = 16'hDEAD; st2 = 0;
        for (int k = 1; k <= 330; k++) begin
            @(negedge clk);
            if (rpm_valid) begin
                n++;
                if (n == 1) begin t1 = k - 1; r1 = rpm; end
                else if (n == 2) begin t2 = k - 1; r2 = rpm; st2 = stalled; end
            end
            @(posedge clk); #1;
        end
        check("stall_count", n, 2);
        check("stall_t1", t1, 34);
        check("stall_r1", r1, 750);
        check("stall_t2", t2, int'(TO));
        check("stall_rpm", r2, 0);
        check("stall_flag", st2, 1);
        pulse(32'd20000);
        wait_result(60, got, lat, r, st);
        check("reprime_valid", got, 1);
        check("reprime_rpm", r, 1500);

        // reset in the middle of the divide
        pulse(32'd30000);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rpm", rpm, 0);
        check("midrst_valid", rpm_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_stalled", stalled, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rpm_valid) n++;
        end
        check("midrst_no_result", n, 0);

        // random stimulus, checked by the monitor every cycle
        for (int i = 0; i < 40; i++) begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 350) : $urandom_range(0, 50);
            repeat (gap) @(posedge clk);
            sel = $urandom_range(0, 3);
            case (sel)
                0: p = 32'($urandom_range(0, 20));
                1: p = 32'($urandom_range(1000, 100000));
                2: p = $urandom;
                default: p = 32'($urandom_range(20000, 40000));
            endcase
            pulse(p);
        end
        repeat (80) @(posedge clk);
        @(negedge clk);
        st_b = busy;
        check("final_idle", st_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
